param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: data word width in bits, >=1.
REQ-002 The block SHALL have parameter DEPTH, default 16: number of storage entries, >=2, any value (not restricted to powers of two).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2: almost-full threshold.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2: almost-empty threshold.
REQ-005 The block SHALL define local CW = clog2(DEPTH+1): width of the occupancy count.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-007 clock  input  1  rising-edge clock for all state.
REQ-008 resetN  input  1  asynchronous active-low reset.
REQ-009 flush  input  1  synchronous discard of all queued entries.
REQ-010 dataIn  input  WIDTH  write data.
REQ-011 push  input  1  write request.
REQ-012 pop  input  1  read request.
REQ-013 dataOut  output  WIDTH  head-of-queue data (show-ahead).
REQ-014 full  output  1  count == DEPTH.
REQ-015 empty  output  1  count == 0.
REQ-016 almostFull  output  1  count >= AF_LEVEL.
REQ-017 almostEmpty  output  1  count <= AE_LEVEL.
REQ-018 count  output  CW  current occupancy.
REQ-019 overflow  output  1  sticky flag: a push was dropped.
REQ-020 underflow  output  1  sticky flag: a pop was ignored.

Function
REQ-021 Storage SHALL be a ring buffer with head (write) and tail (read) pointers over 0..DEPTH-1 and a registered count; pointers SHALL wrap from DEPTH-1 to 0 explicitly, not by modular bit overflow.
REQ-022 full, empty, almostFull and almostEmpty SHALL be decoded combinationally from count only.
REQ-023 Accepted push (push & (~full | pop)): write dataIn to mem[head] and advance head; the entry is visible at dataOut on the next cycle if the FIFO was empty.
REQ-024 Accepted pop (pop & ~empty): advance tail; dataOut SHALL show the next entry the following cycle.
REQ-025 Push and pop in the same cycle with 0 < count < DEPTH: both SHALL be performed and count SHALL be unchanged.
REQ-026 Push and pop while full: both SHALL be performed, count SHALL stay DEPTH, and overflow SHALL NOT be set.
REQ-027 Push and pop while empty: only the push SHALL be performed, count SHALL become 1, and underflow SHALL be set.
REQ-028 Push while full without pop: the write SHALL be dropped, state SHALL be unchanged, and overflow SHALL be set to 1.
REQ-029 Pop while empty without push: state SHALL be unchanged and underflow SHALL be set to 1.
REQ-030 overflow and underflow SHALL remain set until reset or flush.
REQ-031 dataOut SHALL equal mem[tail] when count > 0 and SHALL equal 0 when empty.
REQ-032 flush SHALL take priority over push and pop: the next cycle head=0, tail=0, count=0, overflow=0, underflow=0; the same-cycle push SHALL be discarded.
REQ-033 count SHALL never exceed DEPTH, and every cycle SHALL satisfy head == (tail + count) mod DEPTH.
REQ-034 Memory contents SHALL NOT be reset and SHALL never be observable through dataOut while empty.

Reset
REQ-035 resetN low SHALL immediately, without waiting for a clock edge, force head=0, tail=0, count=0, overflow=0, underflow=0; outputs then read empty=1, full=0, almostEmpty=1, dataOut=0.
REQ-036 Reset asserted mid-operation SHALL discard all queued entries; the first edge after resetN deasserts SHALL process push/pop normally.

Verification (WIDTH=8, DEPTH=5, AF_LEVEL=4, AE_LEVEL=1)
REQ-037 Push 0x11,0x22,0x33,0x44,0x55, then a 6th push 0x66 -> full=1, count=5, overflow=1; five pops return 0x11..0x55 in order; then empty=1, dataOut=0.
REQ-038 Ten push+pop wrap cycles at count=2 -> count stays 2, data order is preserved across the pointer wrap 4->0, and no flag is set.
REQ-039 At count=5, push 0xAA with pop -> the popped entry is the oldest, count=5, overflow=0, and 0xAA is dequeued last.
REQ-040 Empty FIFO, pop alone -> underflow=1, count=0; push+pop while empty -> count=1, dataOut equals the pushed word.
REQ-041 Push 3 entries, then assert flush together with push -> count=0, flags clear, empty=1, and the pushed word is lost.
REQ-042 Drive resetN low between clock edges at count=3 -> count=0 and empty=1 before the next edge; a push after release gives count=1.

Source files
------------

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with show-ahead output.
// Ring buffer of DEPTH entries (any DEPTH >= 2) addressed by explicitly
// wrapping head/tail pointers. A registered occupancy count drives all
// status flags. Overflow and underflow flags are sticky until reset or
// flush. Storage is never reset, and its contents are masked from dataOut
// while the FIFO is empty.
module param_fifo #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             flush,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] dataOut,
  output logic             full,
  output logic             empty,
  output logic             almostFull,
  output logic             almostEmpty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  // Pointer width covers indices 0..DEPTH-1.
  localparam int PW = $clog2(DEPTH);

  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic          overflow_reg, underflow_reg;

  logic do_push, do_pop;

  // Status flags are pure decodes of the registered count.
  assign full        = (count_reg == DEPTH_C);
  assign empty       = (count_reg == '0);
  assign almostFull  = (count_reg >= AF_C);
  assign almostEmpty = (count_reg <= AE_C);
  assign count       = count_reg;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

  // A push while full is still accepted when a pop frees the slot in the
  // same cycle. A pop is accepted only when something is queued, so
  // push+pop on an empty FIFO degenerates to a plain push.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Show-ahead read: the head entry is visible combinationally. Storage is
  // masked to zero when empty, so stale data never leaks out.
  assign dataOut = empty ? '0 : mem[tail_reg];

  // Next-state pointers and count; pointers wrap explicitly at DEPTH-1,
  // because DEPTH need not be a power of two.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (do_push) begin
      head_next = (head_reg == LAST_IDX) ? '0 : head_reg + PW'(1);
    end
    if (do_pop) begin
      tail_next = (tail_reg == LAST_IDX) ? '0 : tail_reg + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Control state: asynchronous clear on reset, and synchronous clear on
  // flush (flush takes priority over push and pop).
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (flush) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      if (push & full & ~pop) begin
        overflow_reg <= 1'b1;
      end
      if (pop & empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  // Storage write; contents are intentionally never reset.
  always_ff @(posedge clock) begin
    if (do_push && !flush) begin
      mem[head_reg] <= dataIn;
    end
  end

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (WIDTH=8, DEPTH=5, AF=4, AE=1).
// Table-driven vectors cover fill/drain, overflow, underflow, full
// push+pop and flush. Hand-written sequences cover the pointer wrap and
// an asynchronous reset applied mid-cycle.
module tb_param_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int AFL   = 4;
  localparam int AEL   = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock;
  logic             resetN;
  logic             flush;
  logic [WIDTH-1:0] dataIn;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] dataOut;
  logic             full;
  logic             empty;
  logic             almostFull;
  logic             almostEmpty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  int checks = 0;
  int errors = 0;

  param_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AF_LEVEL(AFL),
    .AE_LEVEL(AEL)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .flush(flush),
    .dataIn(dataIn),
    .push(push),
    .pop(pop),
    .dataOut(dataOut),
    .full(full),
    .empty(empty),
    .almostFull(almostFull),
    .almostEmpty(almostEmpty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       push;
    logic       pop;
    logic       flush;
    logic [7:0] din;
    int         cnt;
    logic [7:0] dout;
    logic       ov;
    logic       un;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every output against the expected count/data/sticky flags.
  // The four level flags are decoded from the expected count.
  task automatic check_state(input string tag, input int ecnt, input int edout,
                             input int eov, input int eun);
    chk({tag, ".count"}, int'(count), ecnt);
    chk({tag, ".dataOut"}, int'(dataOut), edout);
    chk({tag, ".full"}, int'(full), int'(ecnt == DEPTH));
    chk({tag, ".empty"}, int'(empty), int'(ecnt == 0));
    chk({tag, ".almostFull"}, int'(almostFull), int'(ecnt >= AFL));
    chk({tag, ".almostEmpty"}, int'(almostEmpty), int'(ecnt <= AEL));
    chk({tag, ".overflow"}, int'(overflow), eov);
    chk({tag, ".underflow"}, int'(underflow), eun);
  endtask

  task automatic step(input logic p, input logic po, input logic f, input logic [7:0] d);
    push   = p;
    pop    = po;
    flush  = f;
    dataIn = d;
    @(posedge clock);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
  endtask

  // Watchdog: the run must always terminate.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q [$];
    logic [7:0] exp_d;

    //          push pop flush din    cnt dout   ov    un
    // Fill to full, overflow on a 6th push, then drain in order.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1, 8'h11, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h22, 2, 8'h11, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h33, 3, 8'h11, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h44, 4, 8'h11, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h55, 5, 8'h11, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h66, 5, 8'h11, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 4, 8'h22, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3, 8'h33, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 8'h44, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'h55, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00, 1'b1, 1'b0};
    // Pop alone while empty, then flush clears both sticky flags.
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b0};
    // Push+pop while empty: only the push happens, underflow set.
    vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h77, 1, 8'h77, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b0};
    // Full push+pop: oldest leaves, 0xAA goes to the back, no overflow.
    vecs[15] = '{1'b1, 1'b0, 1'b0, 8'hA1, 1, 8'hA1, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 8'hA2, 2, 8'hA1, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 8'hA3, 3, 8'hA1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 8'hA4, 4, 8'hA1, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 8'hA5, 5, 8'hA1, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 8'hAA, 5, 8'hA2, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 8'h00, 4, 8'hA3, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 8'h00, 3, 8'hA4, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 8'hA5, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'hAA, 1'b0, 1'b0};
    vecs[25] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00, 1'b0, 1'b0};
    // Three entries, then flush with push: everything including C0 is lost.
    vecs[26] = '{1'b1, 1'b0, 1'b0, 8'hB1, 1, 8'hB1, 1'b0, 1'b0};
    vecs[27] = '{1'b1, 1'b0, 1'b0, 8'hB2, 2, 8'hB1, 1'b0, 1'b0};
    vecs[28] = '{1'b1, 1'b0, 1'b0, 8'hB3, 3, 8'hB1, 1'b0, 1'b0};
    vecs[29] = '{1'b1, 1'b0, 1'b1, 8'hC0, 0, 8'h00, 1'b0, 1'b0};
    vecs[30] = '{1'b1, 1'b0, 1'b0, 8'hD1, 1, 8'hD1, 1'b0, 1'b0};
    vecs[31] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00, 1'b0, 1'b0};

    resetN = 1'b0;
    flush  = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    dataIn = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    check_state("reset", 0, 0, 0, 0);
    resetN = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].din);
      $display("vec %0d: push=%b pop=%b flush=%b din=%02h -> count=%0d dout=%02h ov=%b un=%b",
               i, vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].din,
               count, dataOut, overflow, underflow);
      check_state($sformatf("vec%0d", i), vecs[i].cnt, int'(vecs[i].dout),
                  int'(vecs[i].ov), int'(vecs[i].un));
    end

    // Pointer wrap: hold count at 2 with ten push+pop cycles.
    q.delete();
    step(1'b1, 1'b0, 1'b0, 8'hE0); q.push_back(8'hE0);
    step(1'b1, 1'b0, 1'b0, 8'hE1); q.push_back(8'hE1);
    check_state("wrap.prefill", 2, int'(q[0]), 0, 0);
    for (int k = 0; k < 10; k++) begin
      logic [7:0] d;
      d = 8'hE2 + 8'(k);
      step(1'b1, 1'b1, 1'b0, d);
      void'(q.pop_front());
      q.push_back(d);
      $display("wrap %0d: din=%02h -> count=%0d dout=%02h", k, d, count, dataOut);
      check_state($sformatf("wrap%0d", k), 2, int'(q[0]), 0, 0);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    void'(q.pop_front());
    exp_d = q[0];
    check_state("wrap.drain1", 1, int'(exp_d), 0, 0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check_state("wrap.drain2", 0, 0, 0, 0);

    // Asynchronous reset between clock edges at count=3.
    step(1'b1, 1'b0, 1'b0, 8'hF1);
    step(1'b1, 1'b0, 1'b0, 8'hF2);
    step(1'b1, 1'b0, 1'b0, 8'hF3);
    check_state("areset.pre", 3, 8'hF1, 0, 0);
    #2;
    resetN = 1'b0;
    #1;
    $display("areset: count=%0d empty=%b dout=%02h", count, empty, dataOut);
    check_state("areset.mid", 0, 0, 0, 0);
    @(negedge clock);
    resetN = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h5A);
    $display("areset.after: count=%0d dout=%02h", count, dataOut);
    check_state("areset.push", 1, 8'h5A, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
